led_step_sequencer: RTL and testbench

Programmable LED pattern sequencer. Holds a small table of steps, each an LED pattern plus a dwell time in time-base ticks. On go it plays the steps in order, holding each pattern for its dwell. It uses an internal dwell timer for each step and either ends or loops after the last step. It sits between the user control logic and the LED output pins, driven by a shared tick_en time-base strobe.

---
 rtl/led_seq_pkg.sv | 25 ++
 rtl/dwell_timer.sv | 37 +++
 rtl/led_step_sequencer.sv | 130 +++++++++++++
 tb/tb_led_step_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED step sequencer.
//   seq_state_t : sequencer FSM state encoding
//   addr_width  : table index width derived from the table depth
//   entry_width : width of one table entry, laid out as {dwell, pattern}
package led_seq_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'b00,
      StLoad    = 2'b01,
      StDwell   = 2'b10,
      StAdvance = 2'b11
   } seq_state_t;

   // Index width for a table of 'depth' entries; at least one bit.
   function automatic int unsigned addr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Entry layout is {dwell, pattern}; pattern occupies the low num_leds bits.
   function automatic int unsigned entry_width(input int unsigned num_leds,
                                               input int unsigned tick_w);
      return num_leds + tick_w;
   endfunction

endpackage

// File: rtl/dwell_timer.sv
// Per-step dwell timer for the LED step sequencer.
//   clk     : system clock
//   reset   : asynchronous active-high reset
//   start   : load the timer with 'dwell' (a dwell of 0 is treated as 1)
//   dwell   : dwell length in tick_en pulses
//   tick_en : time-base strobe, already gated by the caller to the wait phase
//   expire  : one-cycle pulse in the cycle that carries the final tick
module dwell_timer
   import led_seq_pkg::*;
#(
   parameter int unsigned TICK_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [TICK_W-1:0] dwell,
   input  logic              tick_en,
   output logic              expire
);

   logic [TICK_W-1:0] count;

   // Combinational so the owner can leave its wait state on the very edge
   // that samples the last tick; count returns to 0 afterwards, so it pulses once.
   assign expire = tick_en && !start && (count == TICK_W'(1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (start) begin
         count <= (dwell == '0) ? TICK_W'(1) : dwell;
      end else if (tick_en && (count != '0)) begin
         count <= count - TICK_W'(1);
      end
   end

endmodule

// File: rtl/led_step_sequencer.sv
// Programmable LED pattern sequencer: plays a table of {dwell, pattern} steps
// in order, holding each pattern for its dwell in tick_en pulses, then either
// finishes or wraps to step 0.
//   clk, reset          : clock and asynchronous active-high reset
//   wr_en/wr_addr/...   : table write port, accepted in any state
//   last_step           : final step index, latched when a run starts
//   loop                : wrap after the final step (sampled at each advance)
//   go, stop            : start request (idle only) and abort (highest priority)
//   tick_en             : shared time-base strobe
//   led                 : registered LED drive
//   busy                : high whenever a run is in progress
//   step_idx            : index of the current step
//   done                : one-cycle pulse after a normally completed run
module led_step_sequencer
   import led_seq_pkg::*;
#(
   parameter  int unsigned NUM_LEDS = 8,
   parameter  int unsigned DEPTH    = 8,
   parameter  int unsigned TICK_W   = 4,
   localparam int unsigned ADDR_W   = addr_width(DEPTH)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [NUM_LEDS-1:0] wr_pattern,
   input  logic [TICK_W-1:0]   wr_dwell,
   input  logic [ADDR_W-1:0]   last_step,
   input  logic                loop,
   input  logic                go,
   input  logic                stop,
   input  logic                tick_en,
   output logic [NUM_LEDS-1:0] led,
   output logic                busy,
   output logic [ADDR_W-1:0]   step_idx,
   output logic                done
);

   localparam int unsigned ENTRY_W = entry_width(NUM_LEDS, TICK_W);

   logic [ENTRY_W-1:0] step_table [DEPTH];
   logic [ENTRY_W-1:0] cur_entry;
   seq_state_t         state;
   logic [ADDR_W-1:0]  last_latched;
   logic               timer_start;
   logic               timer_tick;
   logic               expire;

   // Step table; a write only becomes visible when the entry is next loaded.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            step_table[i] <= '0;
         end
      end else if (wr_en) begin
         step_table[wr_addr] <= {wr_dwell, wr_pattern};
      end
   end

   assign cur_entry   = step_table[step_idx];
   assign timer_start = (state == StLoad);
   // Ticks only count while waiting; ticks in load/advance are dropped.
   assign timer_tick  = tick_en && (state == StDwell);

   dwell_timer #(
      .TICK_W (TICK_W)
   ) u_dwell_timer (
      .clk     (clk),
      .reset   (reset),
      .start   (timer_start),
      .dwell   (cur_entry[ENTRY_W-1:NUM_LEDS]),
      .tick_en (timer_tick),
      .expire  (expire)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= StIdle;
         led          <= '0;
         busy         <= 1'b0;
         step_idx     <= '0;
         done         <= 1'b0;
         last_latched <= '0;
      end else if (stop && (state != StIdle)) begin
         state    <= StIdle;
         led      <= '0;
         busy     <= 1'b0;
         step_idx <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            StIdle: begin
               led <= '0;
               if (go && !stop) begin
                  step_idx     <= '0;
                  last_latched <= last_step;
                  busy         <= 1'b1;
                  state        <= StLoad;
               end
            end
            StLoad: begin
               led   <= cur_entry[NUM_LEDS-1:0];
               state <= StDwell;
            end
            StDwell: begin
               if (expire) begin
                  state <= StAdvance;
               end
            end
            StAdvance: begin
               if (step_idx != last_latched) begin
                  step_idx <= step_idx + ADDR_W'(1);
                  state    <= StLoad;
               end else if (loop) begin
                  step_idx <= '0;
                  state    <= StLoad;
               end else begin
                  led      <= '0;
                  busy     <= 1'b0;
                  step_idx <= '0;
                  done     <= 1'b1;
                  state    <= StIdle;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_step_sequencer.sv
// Self-checking bench for led_step_sequencer. Expected output traces are
// built from the table contents and the tick_en schedule: each step shows one
// load cycle (previous pattern), then its own pattern until the max(dwell,1)-th
// tick seen after the load, plus one advance cycle; a finished run ends with a
// done cycle followed by idle.
module tb_led_step_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [7:0] wr_pattern;
   logic [3:0] wr_dwell;
   logic [2:0] last_step;
   logic       loop;
   logic       go;
   logic       stop;
   logic       tick_en;
   logic [7:0] led;
   logic       busy;
   logic [2:0] step_idx;
   logic       done;

   led_step_sequencer #(
      .NUM_LEDS (8),
      .DEPTH    (8),
      .TICK_W   (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_pattern (wr_pattern),
      .wr_dwell   (wr_dwell),
      .last_step  (last_step),
      .loop       (loop),
      .go         (go),
      .stop       (stop),
      .tick_en    (tick_en),
      .led        (led),
      .busy       (busy),
      .step_idx   (step_idx),
      .done       (done)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          done_cnt = 0;
   int          cyc      = 0;
   int          tick_every = 4;  // 0 means tick_en tied high
   logic [7:0]  m_pat [8];
   logic [3:0]  m_dw  [8];
   bit          tk [4096];
   logic [12:0] exp_q [$];       // {led, busy, step_idx, done}

   always @(negedge clk) begin
      if (done === 1'b1) done_cnt <= done_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // One clock with tick_en from the free-running schedule; returns at edge+1.
   task automatic cycle();
      tick_en = (tick_every == 0) ? 1'b1 : ((cyc % tick_every) == tick_every - 1);
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic write_entry(input int a, input logic [7:0] p, input logic [3:0] d);
      wr_en = 1'b1; wr_addr = 3'(a); wr_pattern = p; wr_dwell = d;
      cycle();
      wr_en = 1'b0;
      m_pat[a] = p;
      m_dw[a]  = d;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 8; i++) begin
         m_pat[i] = '0;
         m_dw[i]  = '0;
      end
   endtask

   // mode 0: tied high; mode > 0: every mode-th cycle; mode < 0: random 3/4.
   task automatic set_ticks(input int mode);
      for (int e = 0; e < 4096; e++) begin
         if (mode == 0)     tk[e] = 1'b1;
         else if (mode > 0) tk[e] = ((e % mode) == mode - 1);
         else               tk[e] = (($urandom % 4) != 0);
      end
   endtask

   task automatic build_trace(input int last);
      logic [7:0] prev;
      int e, cnt, dw;
      bit t;
      exp_q.delete();
      prev = '0;
      e = 0;
      for (int s = 0; s <= last; s++) begin
         exp_q.push_back({prev, 1'b1, 3'(s), 1'b0});
         e++;
         exp_q.push_back({m_pat[s], 1'b1, 3'(s), 1'b0});
         e++;
         dw  = (m_dw[s] == 0) ? 1 : int'(m_dw[s]);
         cnt = 0;
         do begin
            t = tk[e];
            exp_q.push_back({m_pat[s], 1'b1, 3'(s), 1'b0});
            e++;
            if (t) cnt++;
         end while (cnt < dw && e < 4000);
         prev = m_pat[s];
      end
      exp_q.push_back({8'h00, 1'b0, 3'd0, 1'b1});
      exp_q.push_back({8'h00, 1'b0, 3'd0, 1'b0});
   endtask

   // Start a non-looping run and compare every cycle against the built trace;
   // with go_noise, go is also pulsed at random while the run is busy.
   task automatic run_trace(input string tag, input int last, input bit go_noise);
      int n;
      last_step = 3'(last);
      loop = 1'b0;
      build_trace(last);
      n = exp_q.size();
      for (int e = 0; e < n; e++) begin
         go = (e == 0) || (go_noise && e > 0 && e < n - 1 && ($urandom % 5) == 0);
         tick_en = tk[e];
         @(posedge clk);
         #1;
         check($sformatf("%s_e%0d", tag, e), {led, busy, step_idx, done}, exp_q[e]);
      end
      go = 1'b0;
      tick_en = 1'b0;
   endtask

   task automatic wait_idx(input logic [2:0] v, input int limit, input string tag);
      int i = 0;
      while (step_idx !== v && i < limit) begin
         cycle();
         i++;
      end
      check({tag, "_reach"}, step_idx, v);
   endtask

   task automatic wait_idle(input int limit, input string tag);
      int i = 0;
      while (busy !== 1'b0 && i < limit) begin
         cycle();
         i++;
      end
      check({tag, "_idle"}, busy, 1'b0);
   endtask

   initial begin
      int d0;
      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_pattern = '0; wr_dwell = '0;
      last_step = '0; loop = 1'b0; go = 1'b0; stop = 1'b0; tick_en = 1'b0;
      clear_model();
      #2;
      check("reset_state", {led, busy, step_idx, done}, 13'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      cycle();

      // Basic run, tick every 4 cycles.
      write_entry(0, 8'h01, 4'd2);
      write_entry(1, 8'h02, 4'd1);
      write_entry(2, 8'h04, 4'd3);
      set_ticks(4);
      run_trace("basic", 2, 1'b0);

      // Loop with wrap, in-flight write, then loop dropped during step 1.
      tick_every = 4;
      last_step = 3'd2; loop = 1'b1;
      d0 = done_cnt;
      go = 1'b1; cycle(); go = 1'b0;
      wait_idx(3'd2, 200, "loop_s2");
      wait_idx(3'd0, 200, "loop_wrap");
      check("wrap_load_led", led, 8'h04);
      cycle();
      check("wrap_led", led, 8'h01);
      wait_idx(3'd1, 200, "loop_s1");
      cycle();
      cycle();
      write_entry(1, 8'h22, 4'd1);
      check("wr_hold_led", led, 8'h02);
      wait_idx(3'd0, 200, "loop_wrap2");
      wait_idx(3'd1, 200, "loop_s1b");
      cycle();
      check("wr_reload_led", led, 8'h22);
      check("loop_no_done", done_cnt - d0, 0);
      loop = 1'b0;
      wait_idx(3'd2, 200, "exit_s2");
      wait_idle(200, "exit");
      cycle(); cycle();
      check("exit_single_done", done_cnt - d0, 1);
      check("exit_outputs", {led, step_idx}, 11'h0);

      // Abort mid-dwell of step 1, then restart from step 0.
      write_entry(1, 8'h02, 4'd1);
      last_step = 3'd2;
      d0 = done_cnt;
      go = 1'b1; cycle(); go = 1'b0;
      wait_idx(3'd1, 200, "abort_s1");
      cycle();
      stop = 1'b1; cycle(); stop = 1'b0;
      check("abort_outputs", {led, busy, step_idx, done}, 13'h0);
      cycle();
      check("abort_no_done", done_cnt - d0, 0);
      set_ticks(4);
      run_trace("restart", 2, 1'b0);

      // go and stop together while idle.
      go = 1'b1; stop = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check($sformatf("go_stop_idle%0d", i), busy, 1'b0);
      end
      go = 1'b0; stop = 1'b0;

      // Dwell edge cases with tick_en tied high and go pulsed while busy.
      write_entry(0, 8'h11, 4'd0);
      write_entry(1, 8'h22, 4'd1);
      write_entry(2, 8'h33, 4'd15);
      set_ticks(0);
      run_trace("dwell_edge", 2, 1'b1);

      // Asynchronous reset between edges mid-run.
      tick_every = 4;
      go = 1'b1; cycle(); go = 1'b0;
      for (int i = 0; i < 6; i++) cycle();
      #3;
      reset = 1'b1;
      #1;
      check("async_reset", {led, busy, step_idx, done}, 13'h0);
      clear_model();
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
      set_ticks(4);
      run_trace("post_reset", 0, 1'b0);

      // Randomized tables, lengths and tick schedules.
      for (int r = 0; r < 6; r++) begin
         for (int a = 0; a < 8; a++) begin
            write_entry(a, 8'($urandom), 4'($urandom));
         end
         set_ticks((r % 2 == 0) ? -1 : 0);
         run_trace($sformatf("rand%0d", r), int'($urandom % 8), 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
